rst_seq_gen: RTL and testbench

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

---
 rtl/rst_seq_pkg.sv | 27 ++
 rtl/rst_seq_tick_div.sv | 47 ++++
 rtl/rst_seq_gen.sv | 133 +++++++++++++
 tb/tb_rst_seq_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_e : sequencer FSM states (HOLD -> RELEASE -> RUN)
//   DEF_*       : default parameter values
//   seq_cnt_w() : width of the shared hold/gap counter
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGE_GAP   = 4;
  localparam int DEF_WDOG_CYCLES = 1024;

  // One counter serves both the HOLD phase and the inter-channel gaps, so
  // it must reach max(HOLD_CYCLES, STAGE_GAP) - 1.
  function automatic int seq_cnt_w(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_tick_div.sv
// Per-channel tick divider.
//   clk, reset : clock, async active-high reset
//   div        : live divide ratio (0 and 1 both mean "tick every cycle")
//   rel_now    : channel is released in the current cycle
//   rel_next   : channel will be released after this edge
//   tick       : registered single-cycle clock-enable pulse
module rst_seq_tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             rel_now,
  input  logic             rel_next,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic             every;

  assign every = (div <= ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!rel_next) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!rel_now || every) begin
      // Release edge: counting starts from 0, so the first tick lands
      // div edges later; ratio 0/1 ticks from the release edge onwards.
      cnt  <= '0;
      tick <= every;
    end else if (cnt >= div - ONE) begin
      // >= rather than == so a live shrink of div wraps immediately.
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + ONE;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Sequenced reset / tick generator.
// Holds all channels in reset for HOLD_CYCLES edges, releases them one by
// one STAGE_GAP edges apart, then runs. Each released channel gets a
// divided tick. soft_rst_i (or a watchdog bite) restarts the sequence.
// Optional watchdog: compiled in only when RST_SEQ_WDOG_EN is defined.
//   clk, reset  : clock, async active-high reset
//   soft_rst_i  : synchronous restart request
//   div_i       : per-channel divide ratios, channel k at [k*DIV_W +: DIV_W]
//   wdog_kick_i : watchdog service strobe
//   rst_o       : per-channel active-high reset
//   tick_o      : per-channel tick pulses
//   seq_done_o  : all channels released
//   wdog_bite_o : single-cycle watchdog timeout pulse
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    soft_rst_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    wdog_kick_i,
  output logic [NUM_CH-1:0]       rst_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic                    seq_done_o,
  output logic                    wdog_bite_o
);

  localparam int              CW        = seq_cnt_w(HOLD_CYCLES, STAGE_GAP);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'(STAGE_GAP - 1);

  seq_state_e          state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [NUM_CH-1:0]   rst_nx;
  logic                done_nx;
  logic                bite_nx;
  logic                restart;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rst_nx   = rst_o;
    done_nx  = seq_done_o;
    case (state)
      ST_HOLD, ST_RELEASE: begin
        if ((state == ST_HOLD    && cnt == HOLD_LAST) ||
            (state == ST_RELEASE && cnt == GAP_LAST)) begin
          cnt_nx = '0;
          // Released channels form a zero run from bit 0 upwards, so the
          // next release is a left shift of the reset vector.
          rst_nx = rst_o << 1;
          if (rst_nx == '0) begin
            state_nx = ST_RUN;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_RELEASE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: ;
    endcase

    // Soft reset and bite share one restart path, so a coincidence
    // restarts only once.
    restart = soft_rst_i | bite_nx;
    if (restart) begin
      state_nx = ST_HOLD;
      cnt_nx   = '0;
      rst_nx   = '1;
      done_nx  = 1'b0;
    end
  end

`ifdef RST_SEQ_WDOG_EN
  localparam int            WW        = $clog2(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wcnt, wcnt_nx;

  always_comb begin
    // A kick on the terminal cycle suppresses the bite.
    bite_nx = (state == ST_RUN) && !wdog_kick_i && (wcnt == WDOG_LAST);
    wcnt_nx = '0;
    if (state == ST_RUN && !wdog_kick_i && !bite_nx && !soft_rst_i)
      wcnt_nx = wcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wcnt <= '0;
    else       wcnt <= wcnt_nx;
  end
`else
  logic unused_wdog;
  assign bite_nx     = 1'b0;
  assign unused_wdog = wdog_kick_i | (WDOG_CYCLES < 2);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      rst_o       <= '1;
      seq_done_o  <= 1'b0;
      wdog_bite_o <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      rst_o       <= rst_nx;
      seq_done_o  <= done_nx;
      wdog_bite_o <= bite_nx;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rst_seq_tick_div #(.DIV_W(DIV_W)) u_div (
      .clk      (clk),
      .reset    (reset),
      .div      (div_i[k*DIV_W +: DIV_W]),
      .rel_now  (~rst_o[k]),
      .rel_next (~rst_nx[k]),
      .tick     (tick_o[k])
    );
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: behavioural model keyed on "edges since the
// sequence (re)started" plus hand-computed pins at specific edges.
// Works with and without RST_SEQ_WDOG_EN.
module tb_rst_seq_gen;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int H  = 16;
  localparam int G  = 4;
  localparam int W  = 32;
  localparam int DN = H + (N - 1) * G;
`ifdef RST_SEQ_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            soft_rst_i = 1'b0;
  logic            wdog_kick_i = 1'b0;
  logic [N*DW-1:0] div_i;
  logic [N-1:0]    rst_o, tick_o;
  logic            seq_done_o, wdog_bite_o;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_CH(N), .DIV_W(DW), .HOLD_CYCLES(H), .STAGE_GAP(G), .WDOG_CYCLES(W)
  ) dut (
    .clk(clk), .reset(reset), .soft_rst_i(soft_rst_i), .div_i(div_i),
    .wdog_kick_i(wdog_kick_i), .rst_o(rst_o), .tick_o(tick_o),
    .seq_done_o(seq_done_o), .wdog_bite_o(wdog_bite_o)
  );

  int total = 0;
  int bad   = 0;
  int gedge = 0;      // edges since reset release
  bit kick_en = 1'b1;
  int kick_at = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, gedge, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int           en;          // edges since last restart
  int           last [N];    // edge of last tick (or release) per channel
  int           wlast;       // edge of RUN entry or last kick
  logic [N-1:0] m_rst, m_tick;
  logic         m_done, m_bite;

  function automatic int ratio(input int k);
    int v;
    v = int'(div_i[k*DW +: DW]);
    return (v <= 1) ? 1 : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      gedge = 0; en = 0; wlast = 0;
      m_rst = '1; m_tick = '0; m_done = 1'b0; m_bite = 1'b0;
    end else begin
      int pre, r;
      bit run, bite;
      gedge++;
      pre  = en;
      run  = (pre >= DN);
      bite = WD && run && !wdog_kick_i && (pre + 1 - wlast >= W);
      if (run && wdog_kick_i) wlast = pre + 1;
      m_bite = bite;
      if (soft_rst_i || bite) begin
        en = 0; m_rst = '1; m_tick = '0; m_done = 1'b0;
      end else begin
        en = pre + 1;
        for (int k = 0; k < N; k++) begin
          r = H + k * G;
          if (en < r) begin
            m_rst[k] = 1'b1; m_tick[k] = 1'b0;
          end else if (en == r) begin
            m_rst[k] = 1'b0; m_tick[k] = (div_i[k*DW +: DW] <= 1); last[k] = r;
          end else begin
            m_rst[k]  = 1'b0;
            m_tick[k] = (en - last[k] >= ratio(k));
            if (m_tick[k]) last[k] = en;
          end
        end
        m_done = (en >= DN);
        if (en == DN) wlast = DN;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_rst", 32'(rst_o), 32'(m_rst));
      chk("model_tick", 32'(tick_o), 32'(m_tick));
      chk("model_done", 32'(seq_done_o), 32'(m_done));
      chk("model_bite", 32'(wdog_bite_o), 32'(m_bite));
    end
  end

  always @(negedge clk)
    wdog_kick_i = (kick_en && (gedge % 20 == 19)) || (gedge == kick_at - 1);

  task automatic run_to(input int n);
    int guard = 0;
    while (gedge < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (gedge != n) begin
      total++; bad++;
      $display("FAIL run_to edge=%0d want=%0d", gedge, n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout edge=%0d", gedge);
    $fatal(1, "timeout");
  end

  initial begin
    div_i = {8'd1, 8'd5, 8'd0, 8'd3};
    repeat (5) @(negedge clk);
    chk("reset_rst", 32'(rst_o), 32'hF);
    chk("reset_tick", 32'(tick_o), 32'h0);
    chk("reset_done", 32'(seq_done_o), 32'h0);
    chk("reset_bite", 32'(wdog_bite_o), 32'h0);
    reset = 1'b0;

    // release timing and ticks
    run_to(15); chk("e15_rst", 32'(rst_o), 32'hF); chk("e15_done", 32'(seq_done_o), 0);
    run_to(16); chk("e16_rst", 32'(rst_o), 32'hE);
    run_to(18); chk("e18_tick0", 32'(tick_o[0]), 0);
    run_to(19); chk("e19_tick0", 32'(tick_o[0]), 1);
    run_to(20); chk("e20_rst", 32'(rst_o), 32'hC); chk("e20_tick1", 32'(tick_o[1]), 1);
    run_to(22); chk("e22_tick0", 32'(tick_o[0]), 1);
    run_to(24); chk("e24_rst", 32'(rst_o), 32'h8);
    run_to(27); chk("e27_done", 32'(seq_done_o), 0);
    run_to(28); chk("e28_rst", 32'(rst_o), 32'h0); chk("e28_done", 32'(seq_done_o), 1);

    // live divider changes
    run_to(30); div_i[7:0] = 8'd2;
    run_to(31); chk("e31_tick0", 32'(tick_o[0]), 1); div_i[23:16] = 8'd2;
    run_to(32); chk("e32_tick0", 32'(tick_o[0]), 0); chk("e32_tick2", 32'(tick_o[2]), 1);
    run_to(33); chk("e33_tick0", 32'(tick_o[0]), 1);

    // soft restart from RUN
    run_to(100); soft_rst_i = 1'b1;
    run_to(101); soft_rst_i = 1'b0;
    chk("e101_rst", 32'(rst_o), 32'hF); chk("e101_done", 32'(seq_done_o), 0);
    run_to(116); chk("e116_rst", 32'(rst_o), 32'hF);
    run_to(117); chk("e117_rst", 32'(rst_o), 32'hE);
    run_to(128); chk("e128_done", 32'(seq_done_o), 0);
    run_to(129); chk("e129_done", 32'(seq_done_o), 1);

    // async reset mid-RELEASE
    @(negedge clk); #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_to(21);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", 32'(rst_o), 32'hF);
    chk("async_done", 32'(seq_done_o), 0);
    chk("async_tick", 32'(tick_o), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_to(15); chk("r15_rst", 32'(rst_o), 32'hF);
    run_to(16); chk("r16_rst", 32'(rst_o), 32'hE);
    run_to(20); chk("r20_rst", 32'(rst_o), 32'hC);
    run_to(28); chk("r28_rst", 32'(rst_o), 32'h0); chk("r28_done", 32'(seq_done_o), 1);

    // watchdog: no kicks, then terminal kick, then bite + soft together
    kick_en = 1'b0;
    kick_at = 120;
`ifdef RST_SEQ_WDOG_EN
    run_to(59); chk("w59_bite", 32'(wdog_bite_o), 0);
    run_to(60); chk("w60_bite", 32'(wdog_bite_o), 1); chk("w60_rst", 32'(rst_o), 32'hF);
    run_to(61); chk("w61_bite", 32'(wdog_bite_o), 0);
    run_to(76); chk("w76_rst", 32'(rst_o), 32'hE);
    run_to(120); chk("w120_bite", 32'(wdog_bite_o), 0); chk("w120_rst", 32'(rst_o), 32'h0);
`endif
    run_to(151); soft_rst_i = 1'b1;
    run_to(152); soft_rst_i = 1'b0;
    chk("w152_rst", 32'(rst_o), 32'hF); chk("w152_done", 32'(seq_done_o), 0);
`ifdef RST_SEQ_WDOG_EN
    chk("w152_bite", 32'(wdog_bite_o), 1);
    run_to(153); chk("w153_bite", 32'(wdog_bite_o), 0);
`endif
    run_to(167); chk("w167_rst", 32'(rst_o), 32'hF);
    run_to(168); chk("w168_rst", 32'(rst_o), 32'hE);
    run_to(180);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
